bcd_seg_display: RTL and testbench
==================================

Name: bcd_seg_display

Overview:
- Parametrised successor to the fixed two-digit angle display.
- Accepts a signed WIDTH-bit value on a valid strobe and converts it to NDIG decimal digits with exact binary-to-BCD conversion: shift-add-3, one bit per clock.
- Drives active-low 7-segment outputs with a sign digit, leading-zero blanking, an overflow indication and a freeze key.
- Sits between weightblock (valid = its done strobe) and the board HEX displays.

Parameters:
- WIDTH, 8: bit width of the signed input value.
- NDIG, 3: number of magnitude digits driven, excluding the sign digit.

Ports:
- clk  input  1  system clock
- KEY  input  4  push buttons, active-low. KEY[0] is the reset (see Behaviour); KEY[1] = freeze; KEY[3:2] unused.
- valid  input  1  one-cycle strobe; value is sampled when high
- value  input  WIDTH  signed two's-complement value to display
- signdisp  output  7  sign digit segments
- disp  output  7*NDIG  digit segments; disp[7k+6:7k] is digit k, k=0 is the ones digit
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  one-cycle pulse, high in the cycle new results first appear on the outputs
- ovf  output  1  high while the displayed value has magnitude >= 10^NDIG

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, taken from KEY[0]: KEY[0]==0 at a clk edge resets the block.
- Segment encoding: active-low, bit order gfedcba.
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Blank: 1111111. Dash: 0111111. Minus: 0111111 on the sign digit.
- Reset values:
  - signdisp and all disp digits = dash (0111111).
  - busy=0, done=0, ovf=0.
  - Pending slot cleared; FSM in IDLE.
  - Reset mid-conversion aborts it; the pending value is discarded.
- Magnitude: mag = |value| as an unsigned WIDTH-bit quantity. The most negative value is exact (e.g. -128 gives mag 128).
- neg = value[WIDTH-1]. The sign is shown only when neg=1; the magnitude of a negative value is always nonzero.
- FSM states:
  - IDLE: if valid, load mag and neg into the shift register, clear the BCD digits, go to SHIFT.
  - SHIFT: exactly WIDTH cycles. Each cycle, every internal BCD digit >= 5 gets +3, then the register shifts left one bit. Internal digit count is ceil(WIDTH*log10 2), independent of NDIG. After WIDTH cycles, go to FIN.
  - FIN (1 cycle): write the result registers. Next state:
    - if valid is high this cycle, load the current value and go to SHIFT;
    - else if the pending slot is full, load pending, clear it, and go to SHIFT;
    - else go to IDLE.
- Pending slot (one deep): valid during SHIFT captures the value into the pending slot. A newer valid overwrites an older pending value, so intermediate values are dropped.
- Result formation at FIN:
  - ovf = any internal digit at index >= NDIG is nonzero.
  - If ovf: all disp digits = dash.
  - Else: digits above the most significant nonzero digit are blank. Digit 0 is always shown, so 0 displays as a lone "0".
  - signdisp = minus if neg, else blank. This also applies on overflow.
- Output stage:
  - Output registers load from the result registers on every clk edge where KEY[1]==1.
  - When KEY[1]==0 (freeze), outputs hold. Conversions, busy and done continue.
  - On release, outputs show the latest result one edge later.
- Latency: valid sampled at edge c (from IDLE) → result registers written at edge c+WIDTH+1 → outputs and done at edge c+WIDTH+2. This is 10 cycles for WIDTH=8. Back-to-back throughput is WIDTH+1 cycles per conversion.
- done is registered and pulses once per completed conversion, regardless of freeze.

Test Plan:
1. KEY[0]=0 for 2 edges, then release → all 4 digits = 0111111; busy=0, done=0, ovf=0.
2. WIDTH=8, NDIG=3, value=-45 valid at edge 0 → after edge 10: signdisp 0111111, disp[20:14] 1111111, disp[13:7] 0011001, disp[6:0] 0010010; done high for exactly 1 cycle; busy high for edges 1-9.
3. value=-128 → signdisp minus, digits 1,2,8 = 1111001, 0100100, 0000000. Then value=0 → sign blank, blank, blank, 1000000.
4. NDIG=2, value=127 → ovf=1, both digits 0111111, sign blank. Then value=99 → ovf=0, digits 9,9.
5. Valids at edges 0 (-10), 3 (37), 5 (55) → -10 shown after edge 10 (sign minus, blank, 1, 0). 55 shown after edge 19. 37 never displayed; done pulses exactly twice.
6. KEY[1]=0 from edge 5 to 20 while converting 63 → outputs hold their prior value, done still pulses at edge 10. 63 appears one edge after KEY[1] returns to 1. KEY[0]=0 at edge 4 of a conversion → dashes, no done pulse, busy=0.

Source files
------------

// File: rtl/bcd_seg_display_if.sv
// Value/result bundle for bcd_seg_display.
//   valid, value       : request strobe and signed value (master -> slave)
//   signdisp, disp     : active-low gfedcba segments, sign digit and NDIG magnitude digits
//   busy, done, ovf    : conversion status (slave -> master)
interface bcd_seg_display_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 3
) ();
  logic                    valid;
  logic signed [WIDTH-1:0] value;
  logic [6:0]              signdisp;
  logic [7*NDIG-1:0]       disp;
  logic                    busy;
  logic                    done;
  logic                    ovf;

  modport master (
    output valid, value,
    input  signdisp, disp, busy, done, ovf
  );

  modport slave (
    input  valid, value,
    output signdisp, disp, busy, done, ovf
  );
endinterface

// File: rtl/bcd_seg_display.sv
// Signed binary to 7-segment display driver.
// A signed WIDTH-bit value, strobed by valid, is converted to BCD with a serial shift-add-3
// (one bit per clock) and shown on NDIG active-low digits plus a sign digit, with leading-zero
// blanking and an overflow (all dashes) indication. One value may wait while a conversion runs.
//   clk    : system clock
//   KEY    : KEY[0] synchronous active-low reset, KEY[1] active-low freeze, KEY[3:2] unused
//   bus    : slave side of bcd_seg_display_if (valid/value in; segments, busy, done, ovf out)
module bcd_seg_display #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 3
) (
  input logic              clk,
  input logic [3:0]        KEY,
  bcd_seg_display_if.slave bus
);
  // Internal BCD digits: ceil(WIDTH * log10(2)).
  localparam int unsigned NBcd = (WIDTH * 30103 + 99999) / 100000;
  localparam int unsigned MaxD = (NBcd > NDIG) ? NBcd : NDIG;
  localparam int unsigned SrW  = 4 * NBcd + WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SegBlank;
    endcase
  endfunction

  // Most negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  state_e                 state_q, state_d;
  logic [SrW-1:0]         sr_q, sr_d, sr_adj;
  logic                   neg_q, neg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   pend_full_q, pend_full_d;
  logic [WIDTH-1:0]       pend_val_q, pend_val_d;
  logic                   res_we;
  logic [6:0]             res_sign_q, nxt_sign;
  logic [7*NDIG-1:0]      res_disp_q, nxt_disp;
  logic                   res_ovf_q, nxt_ovf;
  logic                   res_new_q;
  logic [6:0]             sign_q;
  logic [7*NDIG-1:0]      disp_q;
  logic                   ovf_q, done_q;
  logic [4*MaxD-1:0]      bcd_pad;
  logic [3:0]             dig;
  logic                   seen;
  logic                   unused_key;

  assign unused_key = ^KEY[3:2];

  // Add-3 on every digit >= 5 ahead of the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < NBcd; i++) begin
      if (sr_q[WIDTH+4*i +: 4] >= 4'd5) begin
        sr_adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    res_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid) begin
          sr_d    = {{(4*NBcd){1'b0}}, mag_of(bus.value)};
          neg_d   = bus.value[WIDTH-1];
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {sr_adj[SrW-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
        if (bus.valid) begin
          pend_full_d = 1'b1;
          pend_val_d  = bus.value;
        end
      end
      StFin: begin
        res_we = 1'b1;
        cnt_d  = '0;
        // A fresh valid supersedes anything pending, so the pending slot is dropped too.
        if (bus.valid) begin
          sr_d        = {{(4*NBcd){1'b0}}, mag_of(bus.value)};
          neg_d       = bus.value[WIDTH-1];
          pend_full_d = 1'b0;
          state_d     = StShift;
        end else if (pend_full_q) begin
          sr_d        = {{(4*NBcd){1'b0}}, mag_of(pend_val_q)};
          neg_d       = pend_val_q[WIDTH-1];
          pend_full_d = 1'b0;
          state_d     = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result formation from the finished BCD digits.
  always_comb begin
    bcd_pad                 = '0;
    bcd_pad[4*NBcd-1:0]     = sr_q[SrW-1 -: 4*NBcd];
    nxt_ovf                 = 1'b0;
    for (int unsigned i = NDIG; i < MaxD; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) nxt_ovf = 1'b1;
    end
    nxt_disp = '0;
    seen     = 1'b0;
    dig      = 4'd0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      dig  = bcd_pad[4*k +: 4];
      seen = seen | (dig != 4'd0);
      if (nxt_ovf)               nxt_disp[7*k +: 7] = SegDash;
      else if (seen || (k == 0)) nxt_disp[7*k +: 7] = seg7(dig);
      else                       nxt_disp[7*k +: 7] = SegBlank;
    end
    nxt_sign = neg_q ? SegDash : SegBlank;
  end

  always_ff @(posedge clk) begin
    if (!KEY[0]) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_val_q  <= '0;
      res_sign_q  <= SegDash;
      res_disp_q  <= {NDIG{SegDash}};
      res_ovf_q   <= 1'b0;
      res_new_q   <= 1'b0;
      sign_q      <= SegDash;
      disp_q      <= {NDIG{SegDash}};
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_val_q  <= pend_val_d;
      res_new_q   <= res_we;
      if (res_we) begin
        res_sign_q <= nxt_sign;
        res_disp_q <= nxt_disp;
        res_ovf_q  <= nxt_ovf;
      end
      // done tracks result writes even while the outputs are frozen.
      done_q <= res_new_q;
      if (KEY[1]) begin
        sign_q <= res_sign_q;
        disp_q <= res_disp_q;
        ovf_q  <= res_ovf_q;
      end
    end
  end

  assign bus.signdisp = sign_q;
  assign bus.disp     = disp_q;
  assign bus.ovf      = ovf_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_bcd_seg_display.sv
module tb_bcd_seg_display;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLNK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S5 = 7'b0010010, S4 = 7'b0011001;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk;
  logic [3:0] key;
  int         checks;
  int         failures;
  int         done_cnt;

  bcd_seg_display_if #(.WIDTH(8), .NDIG(3)) bus3 ();
  bcd_seg_display_if #(.WIDTH(8), .NDIG(2)) bus2 ();

  bcd_seg_display #(.WIDTH(8), .NDIG(3)) u3 (.clk(clk), .KEY(key), .bus(bus3));
  bcd_seg_display #(.WIDTH(8), .NDIG(2)) u2 (.clk(clk), .KEY(key), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus3.done) done_cnt++;
  endtask

  // Strobe v on the selected instance at edge 0, then run to just after edge 10.
  task automatic conv(input bit sel2, input logic [7:0] v);
    if (sel2) begin bus2.valid = 1'b1; bus2.value = v; end
    else      begin bus3.valid = 1'b1; bus3.value = v; end
    step();
    bus2.valid = 1'b0;
    bus3.valid = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    key = 4'b1110;
    bus3.valid = 1'b0; bus3.value = '0;
    bus2.valid = 1'b0; bus2.value = '0;
    step(); step();
    key = 4'b1111;
    chk("rst_sign", 32'(bus3.signdisp), 32'(DASH));
    chk("rst_disp", 32'(bus3.disp), 32'({DASH, DASH, DASH}));
    chk("rst_flags", {29'd0, bus3.busy, bus3.done, bus3.ovf}, 32'd0);
    chk("rst_disp2", 32'(bus2.disp), 32'({DASH, DASH}));

    // -45: latency, busy window, done pulse width.
    bus3.valid = 1'b1; bus3.value = 8'hD3;
    step();
    bus3.valid = 1'b0;
    chk("busy_e0", 32'(bus3.busy), 32'd1);
    repeat (8) step();
    chk("busy_e8", 32'(bus3.busy), 32'd1);
    step();
    chk("busy_e9", 32'(bus3.busy), 32'd0);
    chk("disp_e9", 32'(bus3.disp), 32'({DASH, DASH, DASH}));
    chk("done_e9", 32'(bus3.done), 32'd0);
    step();
    chk("m45_done", 32'(bus3.done), 32'd1);
    chk("m45_sign", 32'(bus3.signdisp), 32'(DASH));
    chk("m45_disp", 32'(bus3.disp), 32'({BLNK, S4, S5}));
    step();
    chk("m45_done_off", 32'(bus3.done), 32'd0);

    conv(1'b0, 8'h80);
    chk("m128_sign", 32'(bus3.signdisp), 32'(DASH));
    chk("m128_disp", 32'(bus3.disp), 32'({S1, S2, S8}));
    chk("m128_ovf", 32'(bus3.ovf), 32'd0);
    step();
    conv(1'b0, 8'h00);
    chk("zero_sign", 32'(bus3.signdisp), 32'(BLNK));
    chk("zero_disp", 32'(bus3.disp), 32'({BLNK, BLNK, S0}));
    step();
    conv(1'b0, 8'd100);
    chk("p100_disp", 32'(bus3.disp), 32'({S1, S0, S0}));
    step();
    conv(1'b0, 8'd127);
    chk("p127_disp", 32'(bus3.disp), 32'({S1, S2, S7}));
    chk("p127_ovf", 32'(bus3.ovf), 32'd0);
    step();

    // NDIG=2 overflow boundary.
    conv(1'b1, 8'd127);
    chk("n2_127_ovf", 32'(bus2.ovf), 32'd1);
    chk("n2_127_disp", 32'(bus2.disp), 32'({DASH, DASH}));
    chk("n2_127_sign", 32'(bus2.signdisp), 32'(BLNK));
    step();
    conv(1'b1, 8'd99);
    chk("n2_99_ovf", 32'(bus2.ovf), 32'd0);
    chk("n2_99_disp", 32'(bus2.disp), 32'({S9, S9}));
    step();

    // Back-to-back: -10, then 37 and 55 while busy; 37 is overwritten.
    done_cnt = 0;
    bus3.valid = 1'b1; bus3.value = 8'hF6;
    step();
    for (int e = 1; e <= 30; e++) begin
      bus3.valid = (e == 3) || (e == 5);
      bus3.value = (e == 3) ? 8'd37 : 8'd55;
      step();
      if (e == 10) begin
        chk("b2b_m10_sign", 32'(bus3.signdisp), 32'(DASH));
        chk("b2b_m10_disp", 32'(bus3.disp), 32'({BLNK, S1, S0}));
      end
      if (e == 18) chk("b2b_e18_disp", 32'(bus3.disp), 32'({BLNK, S1, S0}));
      if (e == 19) begin
        chk("b2b_55_disp", 32'(bus3.disp), 32'({BLNK, S5, S5}));
        chk("b2b_55_sign", 32'(bus3.signdisp), 32'(BLNK));
      end
    end
    bus3.valid = 1'b0;
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_final_disp", 32'(bus3.disp), 32'({BLNK, S5, S5}));
    chk("b2b_idle", 32'(bus3.busy), 32'd0);

    // Freeze while converting 63.
    done_cnt = 0;
    bus3.valid = 1'b1; bus3.value = 8'd63;
    step();
    bus3.valid = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      key[1] = !((e >= 5) && (e <= 20));
      step();
      if (e == 10) begin
        chk("frz_done", 32'(bus3.done), 32'd1);
        chk("frz_hold10", 32'(bus3.disp), 32'({BLNK, S5, S5}));
      end
      if (e == 20) chk("frz_hold20", 32'(bus3.disp), 32'({BLNK, S5, S5}));
      if (e == 21) chk("frz_release", 32'(bus3.disp), 32'({BLNK, S6, S3}));
    end
    key = 4'b1111;
    chk("frz_done_cnt", 32'(done_cnt), 32'd1);

    // Reset at edge 4 of a conversion aborts it.
    done_cnt = 0;
    bus3.valid = 1'b1; bus3.value = 8'd42;
    step();
    bus3.valid = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      key[0] = (e != 4);
      step();
      if (e == 4) begin
        chk("abort_disp", 32'(bus3.disp), 32'({DASH, DASH, DASH}));
        chk("abort_sign", 32'(bus3.signdisp), 32'(DASH));
        chk("abort_busy", 32'(bus3.busy), 32'd0);
      end
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_disp_end", 32'(bus3.disp), 32'({DASH, DASH, DASH}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
